// File: rtl/simon_pkg.sv
// simon_pkg: Simon 64/96 types, constants and round/rotate helpers shared by the simon cores.
package simon_pkg;
  localparam int WORD_SIZE = 32;
  localparam int KEY_WORDS = 3;
  localparam int ROUNDS = 42;
  localparam int Z_IDX = 2;
  localparam logic [61:0] Z [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };
  typedef logic [WORD_SIZE-1:0] word_t;
  typedef struct packed {
    word_t l;
    word_t r;
  } data_t;
  typedef logic [KEY_WORDS*WORD_SIZE-1:0] key_t;
  typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_t;
  typedef enum logic {FWD, BWD} dir_e;
  function automatic word_t rol(word_t v, int s);
    return (v << s) | (v >> (WORD_SIZE - s));
  endfunction
  function automatic word_t ror(word_t v, int s);
    return rol(v, WORD_SIZE - s);
  endfunction
  function automatic word_t f(word_t v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction
  // z bits are stored MSB-first, so bit i of the sequence sits at position 61-i
  function automatic logic z_bit(int i);
    return Z[Z_IDX][61 - (i % 62)];
  endfunction
endpackage

// File: rtl/simon_key_step.sv
// simon_key_step: one Simon key-schedule step, forward (k[i+m] from k[i..i+m-1]) or backward (k[j-m] from k[j-m+1..j]).
module simon_key_step
  import simon_pkg::*;
#(
  parameter dir_e DIR = FWD
) (
  input  key_t       kr,
  input  logic [7:0] idx,
  output key_t       kr_next
);
  localparam int N = WORD_SIZE;
  localparam int M = KEY_WORDS;
  word_t a, b, t, nk;
  // forward: idx is i, register is {k[i+m-1]..k[i]}; backward: idx is j, register is {k[j]..k[j-m+1]}
  always_comb begin
    a = DIR == FWD ? kr[(M-1)*N +: N] : kr[(M-2)*N +: N];
    b = DIR == FWD ? kr[0 +: N] : kr[(M-1)*N +: N];
    t = ror(a, 3) ^ (M == 4 ? (DIR == FWD ? kr[N +: N] : kr[0 +: N]) : '0);
    t = t ^ ror(t, 1);
    nk = ~b ^ t ^ word_t'(z_bit(DIR == FWD ? int'(idx) : int'(idx) + 62 - M)) ^ word_t'(3);
    kr_next = DIR == FWD ? {nk, kr[M*N-1:N]} : {kr[(M-1)*N-1:0], nk};
  end
endmodule

// File: rtl/simon_decrypt.sv
// simon_decrypt: iterative Simon 64/96 decryption, forward key expansion then one inverse round per cycle.
// Optional SIMON_DEC_KEY_CACHE_EN caches the expanded tail keys to skip EXPAND when the key repeats.
module simon_decrypt
  import simon_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  data_t ciphertext,
  input  key_t  key,
  output data_t plaintext,
  output logic  eoc,
  output logic  trigger
);
  localparam int KW = KEY_WORDS * WORD_SIZE;
  state_t st, st_n;
  word_t x, y, ny;
  key_t kr, kr_f, kr_b, kr_ld;
  logic [5:0] rc;
  logic accept, hit, exp_last, dec_last;
  simon_key_step #(.DIR(FWD)) u_fwd (.kr(kr), .idx({2'b0, rc}), .kr_next(kr_f));
  simon_key_step #(.DIR(BWD)) u_bwd (.kr(kr), .idx(8'(ROUNDS - 1) - {2'b0, rc}), .kr_next(kr_b));
`ifdef SIMON_DEC_KEY_CACHE_EN
  key_t ck_key, ck_kr;
  logic ck_valid;
  assign hit = ck_valid && key == ck_key;
  assign kr_ld = hit ? ck_kr : key;
  always_ff @(posedge clk) begin
    if (rst) begin
      ck_valid <= 1'b0;
      ck_key <= '0;
      ck_kr <= '0;
    end else if (accept && !hit) begin
      ck_key <= key;
      ck_valid <= 1'b0;
    end else if (st == EXPAND && exp_last) begin
      ck_kr <= kr_f;
      ck_valid <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
  assign kr_ld = key;
`endif
  assign accept = (st == IDLE || st == DONE) && start;
  assign exp_last = rc == 6'(ROUNDS - KEY_WORDS - 1);
  assign dec_last = rc == 6'(ROUNDS - 1);
  assign ny = x ^ f(y) ^ kr[KW-1 -: WORD_SIZE];
  always_ff @(posedge clk) st <= rst ? IDLE : st_n;
  always_comb begin
    st_n = accept ? (hit ? DECRYPT : EXPAND) :
           st == EXPAND && exp_last ? DECRYPT :
           st == DECRYPT && dec_last ? DONE : st;
    trigger = st == DECRYPT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      kr <= '0;
      rc <= '0;
      plaintext <= '0;
      eoc <= 1'b0;
    end else if (accept) begin
      x <= ciphertext.l;
      y <= ciphertext.r;
      kr <= kr_ld;
      rc <= '0;
      eoc <= 1'b0;
    end else if (st == EXPAND) begin
      kr <= kr_f;
      rc <= exp_last ? 6'd0 : rc + 6'd1;
    end else if (st == DECRYPT) begin
      x <= y;
      y <= ny;
      kr <= kr_b;
      rc <= rc + 6'd1;
      if (dec_last) begin
        plaintext <= data_t'({y, ny});
        eoc <= 1'b1;
      end
    end
  end
endmodule

// File: doc/simon_decrypt.md
Name: simon_decrypt

Overview:
- Iterative Simon 64/96 decryption core, the inverse of the existing `simon` encryption core. Same data_t/key_t types, same start/eoc handshake.
- Takes a ciphertext and the master key, then recovers the plaintext one round per cycle.
- Round keys are consumed in reverse order. A forward key-expansion phase first reaches the last KEY_WORDS round keys; the schedule is then run backwards during the inverse rounds.

Parameters:
- WORD_SIZE, simon_pkg::WORD_SIZE (32): word width n; the block is 2n wide.
- KEY_WORDS, simon_pkg::KEY_WORDS (3): key words m.
- ROUNDS, simon_pkg::ROUNDS (42): round count T.
- Z_IDX, simon_pkg::Z_IDX (2): index of the z-sequence constant.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- ciphertext  in  data_t (2n)  {L,R} input block; captured on accepted start.
- key  in  key_t (m·n)  master key {k[m-1]..k[0]}; captured on accepted start.
- plaintext  out  data_t (2n)  decrypted {L,R}.
- eoc  out  1  end of computation, level signal.
- trigger  out  1  high during every DECRYPT cycle; used as the scope trigger.

Behaviour:
- Reset: one clock and reset domain; rst is synchronous and active-high.
  - rst=1 at a posedge: state to IDLE; plaintext, eoc, trigger to 0; internal registers cleared.
  - rst has priority over everything, including mid-EXPAND and mid-DECRYPT; the operation is abandoned.
- FSM states: IDLE, EXPAND, DECRYPT, DONE.
  - IDLE/DONE with start=1: capture ciphertext into (x,y), load the key register with the key words, clear the round counter rc, go to EXPAND. eoc falls in the same edge.
  - EXPAND: one forward schedule step per cycle: k[i+m] = ~k[i] ^ tmp ^ z[i] ^ 3, where tmp = S^-3 k[i+m-1] (^ k[i+1] if m=4), then tmp ^= S^-1 tmp. Runs T-m cycles (39), then the register holds k[T-m]..k[T-1]. Go to DECRYPT.
  - DECRYPT: one inverse round per cycle using the current top key k[j], j = T-1 down to 0:
    - (x,y) <= (y, x ^ f(y) ^ k[j]), with f(v) = (S1 v & S8 v) ^ S2 v.
    - Key register steps backward: k[j-m] = ~k[j] ^ tmp ^ z[j-m] ^ 3, with tmp built from k[j-m+1..j-1] exactly as in the forward step.
    - T cycles; after the last one go to DONE.
  - DONE: plaintext = {x,y}, registered; eoc=1. Both are held until the next accepted start or rst.
- Latency: the start edge is cycle 0; eoc=1 after 1+(T-m)+T = 82 rising edges.
- start in EXPAND/DECRYPT is ignored. Inputs may change freely after capture.
- Rotations are modulo WORD_SIZE. z-bit indexing uses (i mod 62).

Optional Feature:
- Macro: SIMON_DEC_KEY_CACHE_EN.
- Defined:
  - At the end of EXPAND, the last m round keys and a copy of the master key are stored.
  - On an accepted start whose key equals the cached master key (cache valid, set after the first completed EXPAND, cleared by rst), EXPAND is skipped: load from the cache and go straight to DECRYPT. Latency becomes 1+T = 43.
  - A different key takes the full path and refreshes the cache.
- Undefined: EXPAND always runs; no cache registers are built.

Decomposition:
- simon_pkg: WORD_SIZE, KEY_WORDS, ROUNDS, Z_IDX, Z constant table, data_t (struct L,R), key_t, and the rotate/f functions shared with `simon`.
- Sub-module simon_key_step: combinational, parameter DIR (forward/backward); computes the next key word and the shifted key register from (key regs, round index).

Test Plan:
1. Known vector: key=131211100b0a090803020100, ciphertext=5ca2e27f111a8fc8, start pulse → eoc at edge 82, plaintext=6f7220676e696c63.
2. Round trip: 20 random keys/plaintexts run through `simon`; its ciphertext is fed to simon_decrypt → plaintext equals the original in every case; trigger high for exactly 42 cycles per run.
3. start held high through a whole run, plus pulses during EXPAND/DECRYPT → no restart; result identical to test 1.
4. rst=1 at cycle 50 (inside DECRYPT) → next cycle eoc=0, plaintext=0, state IDLE; a fresh start then gives the correct test 1 result.
5. Back-to-back: start asserted in the DONE cycle → eoc drops the next cycle; second result correct at edge 82 relative to the new start.
6. With SIMON_DEC_KEY_CACHE_EN: repeat test 1 → second run latency 43. Then a new key → latency 82 and correct plaintext. After rst → latency 82.
